// File: rtl/tdm_pkg.sv
// Shared constants, types and state enum for the TDM receive path.
// Build option: TDM_DEMUX_PARITY_EN adds a 17th parity slot per frame.
package tdm_pkg;

  localparam int unsigned TDM_SLOTS = 16;
  localparam int unsigned TDM_SEL_W = 4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned TDM_T_W  = 5;
  localparam int unsigned TDM_LAST = 16;
`else
  localparam int unsigned TDM_T_W  = 4;
  localparam int unsigned TDM_LAST = 15;
`endif

  typedef logic [TDM_SEL_W-1:0] tdm_slot_t;
  typedef logic [TDM_SLOTS-1:0] tdm_frame_t;
  typedef logic [TDM_T_W-1:0]   tdm_cnt_t;

  typedef enum logic {IDLE, FILL} tdm_state_e;

endpackage

// File: rtl/demux14.sv
// 1-to-4 one-hot enable decoder, one node of the slot write-enable tree.
module demux14 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  // One-hot output, all zero when not enabled
  assign y = {4{en}} & (4'b0001 << sel);

endmodule

// File: rtl/tdm_demux16.sv
// Serial-to-parallel receiver for the 16-slot TDM link with valid/ack frame output.
// Build option: TDM_DEMUX_PARITY_EN -> 17-slot frames, even parity, parity_err port.
module tdm_demux16
  import tdm_pkg::*;
#(
  parameter int unsigned SLOTS = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               din,
  input  logic               din_valid,
  input  logic               sync,
  output logic [TDM_T_W-1:0] t,
  output logic [15:0]        w,
  output logic               frame_valid,
  input  logic               frame_ack,
  output logic               overrun,
`ifdef TDM_DEMUX_PARITY_EN
  output logic               parity_err,
`endif
  output logic               resync
);

  if (SLOTS != TDM_SLOTS || SEL_W != TDM_SEL_W) begin : g_bad_cfg
    $error("tdm_demux16 supports only SLOTS=16, SEL_W=4");
  end

  tdm_state_e state;
  tdm_frame_t acc;
  tdm_frame_t acc_next;
  tdm_frame_t we;
  tdm_slot_t  slot;
  logic [3:0] grp;
  logic       load;
  logic       wr_en;
  logic       done;

  assign slot = t[TDM_SEL_W-1:0];
  assign load = din_valid & ~sync;
  assign done = load && (t == TDM_T_W'(TDM_LAST));

`ifdef TDM_DEMUX_PARITY_EN
  // The parity slot (t=16) never writes acc
  assign wr_en = load & ~t[TDM_T_W-1];
`else
  assign wr_en = load;
`endif

  // Two-level decoder tree: t[3:2] picks a group, t[1:0] picks the bit
  demux14 u_root (.en(wr_en), .sel(slot[3:2]), .y(grp));

  for (genvar g = 0; g < 4; g++) begin : g_leaf
    demux14 u_leaf (.en(grp[g]), .sel(slot[1:0]), .y(we[4*g +: 4]));
  end

  // Accumulator with the current bit merged in, used for both fill and completion
  assign acc_next = (acc & ~we) | (we & {TDM_SLOTS{din}});

  // Slot counter, accumulator, frame register and handshake flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      t           <= '0;
      acc         <= '0;
      w           <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      resync      <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      resync <= 1'b0;
      if (frame_ack) frame_valid <= 1'b0;
      if (din_valid) begin
        if (sync) begin
          acc    <= {{(TDM_SLOTS-1){1'b0}}, din};
          t      <= TDM_T_W'(1);
          resync <= (state == FILL);
          state  <= FILL;
        end else if (done) begin
          w           <= acc_next;
          acc         <= '0;
          t           <= '0;
          state       <= IDLE;
          frame_valid <= 1'b1;
          if (frame_valid && !frame_ack) overrun <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
          parity_err  <= ^{acc, din};
`endif
        end else begin
          acc   <= acc_next;
          t     <= t + TDM_T_W'(1);
          state <= FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux16.sv
// Scoreboard bench for tdm_demux16: stimulus pushes expected frames, a monitor checks them.
module tb_tdm_demux16;
  import tdm_pkg::*;

  localparam int unsigned TW = TDM_T_W;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          sync = 1'b0;
  logic          frame_ack = 1'b0;
  logic [TW-1:0] t;
  logic [15:0]   w;
  logic          frame_valid;
  logic          overrun;
  logic          resync;
`ifdef TDM_DEMUX_PARITY_EN
  logic          parity_err;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  tdm_demux16 dut (
    .clk(clk),
    .resetn(resetn),
    .din(din),
    .din_valid(din_valid),
    .sync(sync),
    .t(t),
    .w(w),
    .frame_valid(frame_valid),
    .frame_ack(frame_ack),
    .overrun(overrun),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err(parity_err),
`endif
    .resync(resync)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; inputs return to idle just after the edge
  task automatic tick(input logic dv, input logic d, input logic s, input logic a);
    @(negedge clk);
    din_valid = dv; din = d; sync = s; frame_ack = a;
    @(posedge clk);
    #1;
    din_valid = 1'b0; din = 1'b0; sync = 1'b0; frame_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    idle(2);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // One full frame, sync on slot 0, optional gaps, optional ack on the last accept
  task automatic send_frame(input logic [15:0] data, input int gap, input logic ack_last,
                            input logic exp_rs, input logic par_flip);
    int n;
    logic b;
    n = TDM_LAST + 1;
    exp_q.push_back(data);
    for (int i = 0; i < n; i++) begin
      if (i < 16) b = data[i];
      else        b = (^data) ^ par_flip;
      tick(1'b1, b, (i == 0), ack_last && (i == n - 1));
      if (i == 0) check("resync_pulse", {31'b0, resync}, {31'b0, exp_rs});
      if (i == 1) check("resync_clear", {31'b0, resync}, 32'd0);
      if (i < n - 1) idle(gap);
    end
  endtask

  // Monitor: a frame is presented when frame_valid rises or w changes while valid
  logic        fv_q = 1'b0;
  logic [15:0] w_q = 16'h0;
  always @(negedge clk) begin
    logic [15:0] e;
    if (!resetn) begin
      fv_q <= 1'b0;
      w_q  <= 16'h0;
    end else begin
      if (frame_valid && (!fv_q || (w !== w_q))) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got %0h expected none", w);
        end else begin
          e = exp_q.pop_front();
          check("frame_w", {16'b0, w}, {16'b0, e});
        end
      end
      fv_q <= frame_valid;
      w_q  <= w;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    check("rst_t", 32'(t), 32'd0);
    check("rst_w", {16'b0, w}, 32'd0);
    check("rst_fv", {31'b0, frame_valid}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    check("rst_resync", {31'b0, resync}, 32'd0);

    // 1: basic frame
    send_frame(16'hA5C3, 0, 1'b0, 1'b0, 1'b0);
    check("t1_fv", {31'b0, frame_valid}, 32'd1);
    check("t1_w", {16'b0, w}, 32'h0000A5C3);
    check("t1_t", 32'(t), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_ack", {31'b0, frame_valid}, 32'd0);

    // 2: same frame with 3-cycle gaps between accepts
    send_frame(16'hA5C3, 3, 1'b0, 1'b0, 1'b0);
    check("t2_fv", {31'b0, frame_valid}, 32'd1);
    check("t2_w", {16'b0, w}, 32'h0000A5C3);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // 3: partial frame of ones, then resync into 16'h00FF
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (6) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("t3_partial_t", 32'(t), 32'd7);
    send_frame(16'h00FF, 0, 1'b0, 1'b1, 1'b0);
    check("t3_w", {16'b0, w}, 32'h000000FF);
    check("t3_overrun", {31'b0, overrun}, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // 4: back-to-back frames without ack
    send_frame(16'h1234, 0, 1'b0, 1'b0, 1'b0);
    check("t4_no_overrun_yet", {31'b0, overrun}, 32'd0);
    send_frame(16'hFFFF, 0, 1'b0, 1'b0, 1'b0);
    check("t4_overrun", {31'b0, overrun}, 32'd1);
    check("t4_w", {16'b0, w}, 32'h0000FFFF);
    idle(2);
    check("t4_overrun_sticky", {31'b0, overrun}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_ack", {31'b0, frame_valid}, 32'd0);
    check("t4_overrun_after_ack", {31'b0, overrun}, 32'd1);

    // 5: ack in the completion cycle of frame 2
    do_reset();
    check("t5_rst_overrun", {31'b0, overrun}, 32'd0);
    send_frame(16'h0F0F, 0, 1'b0, 1'b0, 1'b0);
    send_frame(16'h3C3C, 0, 1'b1, 1'b0, 1'b0);
    check("t5_fv", {31'b0, frame_valid}, 32'd1);
    check("t5_overrun", {31'b0, overrun}, 32'd0);
    check("t5_w", {16'b0, w}, 32'h00003C3C);

    // 6: asynchronous reset mid-frame with a pending frame
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (8) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_pre_t", 32'(t), 32'd9);
    check("t6_pre_fv", {31'b0, frame_valid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_t", 32'(t), 32'd0);
    check("t6_w", {16'b0, w}, 32'd0);
    check("t6_fv", {31'b0, frame_valid}, 32'd0);
    check("t6_overrun", {31'b0, overrun}, 32'd0);
    check("t6_resync", {31'b0, resync}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

`ifdef TDM_DEMUX_PARITY_EN
    check("t6_parity_rst", {31'b0, parity_err}, 32'd0);
    send_frame(16'h0001, 0, 1'b0, 1'b0, 1'b1);
    check("t6_parity_err", {31'b0, parity_err}, 32'd1);
    check("t6_parity_w", {16'b0, w}, 32'h00000001);
`endif

    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
